// File: rtl/mfspm_port_arbiter_if.sv
// Bus bundle for the SPM port arbiter: host front-end request/response,
// IOP408 byte read/write ports and the SRAM macro port.
interface mfspm_port_arbiter_if #(
  parameter int AW = 12
);
  // Host front end
  logic          host_req;
  logic          host_lock;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [63:0]   host_wdata;
  logic [7:0]    host_be;
  logic          host_gnt;
  logic          host_rvalid;
  logic [63:0]   host_rdata;

  // IOP408 byte read port
  logic          IOPRREQ;
  logic [20:0]   IOPRADDR;
  logic [7:0]    IOPRDATA;
  logic          IOPRWAIT;

  // IOP408 byte write port
  logic          IOPWREQ;
  logic [20:0]   IOPWADDR;
  logic [7:0]    IOPWDATA;
  logic          IOPWWAIT;

  // SRAM macro
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [63:0]   ram_wdata;
  logic [7:0]    ram_be;
  logic [63:0]   ram_rdata;

  // Arbiter side
  modport slave (
    input  host_req, host_lock, host_we, host_addr, host_wdata, host_be,
    output host_gnt, host_rvalid, host_rdata,
    input  IOPRREQ, IOPRADDR,
    output IOPRDATA, IOPRWAIT,
    input  IOPWREQ, IOPWADDR, IOPWDATA,
    output IOPWWAIT,
    output ram_en, ram_we, ram_addr, ram_wdata, ram_be,
    input  ram_rdata
  );

  // Requester / SRAM side
  modport master (
    output host_req, host_lock, host_we, host_addr, host_wdata, host_be,
    input  host_gnt, host_rvalid, host_rdata,
    output IOPRREQ, IOPRADDR,
    input  IOPRDATA, IOPRWAIT,
    output IOPWREQ, IOPWADDR, IOPWDATA,
    input  IOPWWAIT,
    input  ram_en, ram_we, ram_addr, ram_wdata, ram_be,
    output ram_rdata
  );
endinterface

// File: rtl/mfspm_port_arbiter.sv
// Single-port 64-bit SPM bank arbiter: round-robin between host, IOP write
// and IOP read, with a bounded host burst lock and fixed one-cycle read
// latency for both host and IOP read data.
module mfspm_port_arbiter #(
  parameter int AW       = 12,
  parameter int LOCK_MAX = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  mfspm_port_arbiter_if.slave  bus
);

  localparam int LCW = $clog2(LOCK_MAX + 1);
  localparam logic [LCW-1:0] LOCK_MAX_C = LCW'(LOCK_MAX);

  typedef enum logic [1:0] {
    REQ_H = 2'd0,
    REQ_W = 2'd1,
    REQ_R = 2'd2
  } req_e;

  req_e           ptr_q, ptr_d;
  logic           rd_pend_q, rd_pend_d;
  logic [2:0]     lane_q, lane_d;
  logic           hrd_pend_q, hrd_pend_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;

  logic h_el, w_el, r_el, h_rr, lock_ok;
  logic gnt_h, gnt_w, gnt_r;

  // Upper byte-address bits lie outside the bank and are ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{bus.IOPRADDR[20:AW+3], bus.IOPWADDR[20:AW+3]};

  // Eligibility and single-grant selection (lock first, then round-robin).
  always_comb begin
    h_el    = bus.host_req;
    w_el    = bus.IOPWREQ;
    r_el    = bus.IOPRREQ & ~rd_pend_q;
    lock_ok = lock_cnt_q < LOCK_MAX_C;
    // Once the lock budget is spent, host yields to any waiting IOP port.
    h_rr    = h_el & ~((lock_cnt_q == LOCK_MAX_C) & (w_el | r_el));
    gnt_h   = 1'b0;
    gnt_w   = 1'b0;
    gnt_r   = 1'b0;
    if (bus.host_lock & h_el & lock_ok) begin
      gnt_h = 1'b1;
    end else begin
      unique case (ptr_q)
        REQ_H: begin
          if (w_el)      gnt_w = 1'b1;
          else if (r_el) gnt_r = 1'b1;
          else if (h_rr) gnt_h = 1'b1;
        end
        REQ_W: begin
          if (r_el)      gnt_r = 1'b1;
          else if (h_rr) gnt_h = 1'b1;
          else if (w_el) gnt_w = 1'b1;
        end
        default: begin
          if (h_rr)      gnt_h = 1'b1;
          else if (w_el) gnt_w = 1'b1;
          else if (r_el) gnt_r = 1'b1;
        end
      endcase
    end
  end

  // Next-state for pointer, pending-read flags, read lane and lock counter.
  always_comb begin
    ptr_d      = ptr_q;
    rd_pend_d  = gnt_r;
    lane_d     = lane_q;
    hrd_pend_d = gnt_h & ~bus.host_we;
    lock_cnt_d = lock_cnt_q;

    if (gnt_h)      ptr_d = REQ_H;
    else if (gnt_w) ptr_d = REQ_W;
    else if (gnt_r) ptr_d = REQ_R;

    if (gnt_r) lane_d = bus.IOPRADDR[2:0];

    if (!bus.host_lock || gnt_w || gnt_r) begin
      lock_cnt_d = '0;
    end else if (gnt_h && (w_el || r_el) && lock_ok) begin
      lock_cnt_d = lock_cnt_q + LCW'(1);
    end
  end

  // State registers; reset drops any in-flight read.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ptr_q      <= REQ_R;
      rd_pend_q  <= 1'b0;
      lane_q     <= '0;
      hrd_pend_q <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rd_pend_q  <= rd_pend_d;
      lane_q     <= lane_d;
      hrd_pend_q <= hrd_pend_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // SRAM drive from the granted requester; all zero when idle.
  always_comb begin
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    bus.ram_be    = '0;
    if (gnt_h) begin
      bus.ram_en    = 1'b1;
      bus.ram_we    = bus.host_we;
      bus.ram_addr  = bus.host_addr;
      bus.ram_wdata = bus.host_wdata;
      bus.ram_be    = bus.host_be;
    end else if (gnt_w) begin
      bus.ram_en    = 1'b1;
      bus.ram_we    = 1'b1;
      bus.ram_addr  = bus.IOPWADDR[AW+2:3];
      bus.ram_wdata = {8{bus.IOPWDATA}};
      bus.ram_be    = 8'b1 << bus.IOPWADDR[2:0];
    end else if (gnt_r) begin
      bus.ram_en    = 1'b1;
      bus.ram_addr  = bus.IOPRADDR[AW+2:3];
      bus.ram_be    = 8'hFF;
    end
  end

  // Requester handshakes and returned read data.
  always_comb begin
    bus.host_gnt    = gnt_h;
    bus.host_rvalid = hrd_pend_q;
    bus.host_rdata  = hrd_pend_q ? bus.ram_rdata : '0;
    bus.IOPWWAIT    = bus.IOPWREQ & ~gnt_w;
    bus.IOPRWAIT    = bus.IOPRREQ & ~rd_pend_q;
    bus.IOPRDATA    = rd_pend_q ? bus.ram_rdata[{lane_q, 3'b000} +: 8] : '0;
  end

endmodule

// File: tb/tb_mfspm_port_arbiter.sv
// Directed bench for mfspm_port_arbiter with a behavioural SRAM model.
module tb_mfspm_port_arbiter;
  localparam int AW       = 12;
  localparam int LOCK_MAX = 16;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  mfspm_port_arbiter_if #(.AW(AW)) bus ();

  mfspm_port_arbiter #(.AW(AW), .LOCK_MAX(LOCK_MAX)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  always #5 HCLK = ~HCLK;

  // SRAM model: byte-enabled write, registered read data.
  logic [63:0] mem [0:4095];
  logic [63:0] rdata_q = '0;
  always @(posedge HCLK) begin
    if (bus.ram_en) begin
      if (bus.ram_we) begin
        for (int b = 0; b < 8; b++)
          if (bus.ram_be[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
      end else begin
        rdata_q <= mem[bus.ram_addr];
      end
    end
  end
  assign bus.ram_rdata = rdata_q;

  task automatic idle();
    bus.host_req = 0; bus.host_lock = 0; bus.host_we = 0; bus.host_addr = '0;
    bus.host_wdata = '0; bus.host_be = '0;
    bus.IOPRREQ = 0; bus.IOPRADDR = '0;
    bus.IOPWREQ = 0; bus.IOPWADDR = '0; bus.IOPWDATA = '0;
  endtask

  task automatic test_reset();
    idle();
    HRESETn = 0;
    @(negedge HCLK); #1;
    total++;
    if ({bus.ram_en, bus.ram_we, bus.host_gnt, bus.host_rvalid, bus.IOPWWAIT, bus.IOPRWAIT} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=000000",
        {bus.ram_en, bus.ram_we, bus.host_gnt, bus.host_rvalid, bus.IOPWWAIT, bus.IOPRWAIT});
    end
    total++;
    if ({bus.ram_addr, bus.ram_be, bus.ram_wdata, bus.host_rdata, bus.IOPRDATA} !== '0) begin
      bad++; $display("FAIL reset_data got addr=%h be=%h wd=%h hrd=%h ird=%h exp all zero",
        bus.ram_addr, bus.ram_be, bus.ram_wdata, bus.host_rdata, bus.IOPRDATA);
    end
    @(negedge HCLK);
    HRESETn = 1;
  endtask

  task automatic test_iop_write();
    @(negedge HCLK); idle();
    bus.IOPWREQ = 1; bus.IOPWADDR = 21'h00005; bus.IOPWDATA = 8'hA5;
    #1;
    total++;
    if ({bus.IOPWWAIT, bus.ram_en, bus.ram_we} !== 3'b011) begin
      bad++; $display("FAIL iopw_ctrl got=%b exp=011", {bus.IOPWWAIT, bus.ram_en, bus.ram_we});
    end
    total++;
    if (bus.ram_addr !== 12'd0 || bus.ram_be !== 8'h20) begin
      bad++; $display("FAIL iopw_addr_be got addr=%h be=%h exp addr=000 be=20", bus.ram_addr, bus.ram_be);
    end
    total++;
    if (bus.ram_wdata !== 64'hA5A5A5A5A5A5A5A5) begin
      bad++; $display("FAIL iopw_wdata got=%h exp=a5a5a5a5a5a5a5a5", bus.ram_wdata);
    end
  endtask

  task automatic test_iop_read();
    @(negedge HCLK); idle();
    bus.IOPRREQ = 1; bus.IOPRADDR = 21'h00005;
    #1;
    total++;
    if ({bus.IOPRWAIT, bus.ram_en, bus.ram_we, bus.ram_be} !== {3'b110, 8'hFF} || bus.ram_addr !== 12'd0) begin
      bad++; $display("FAIL iopr_grant got wait/en/we=%b be=%h addr=%h exp 110 ff 000",
        {bus.IOPRWAIT, bus.ram_en, bus.ram_we}, bus.ram_be, bus.ram_addr);
    end
    @(negedge HCLK); #1;
    total++;
    if ({bus.IOPRWAIT, bus.ram_en} !== 2'b00 || bus.IOPRDATA !== 8'hA5) begin
      bad++; $display("FAIL iopr_data got wait/en=%b data=%h exp 00 a5", {bus.IOPRWAIT, bus.ram_en}, bus.IOPRDATA);
    end
    @(negedge HCLK); idle(); #1;
    total++;
    if (bus.IOPRDATA !== 8'h00) begin
      bad++; $display("FAIL iopr_after got=%h exp=00", bus.IOPRDATA);
    end
  endtask

  task automatic test_round_robin();
    @(negedge HCLK); idle(); HRESETn = 0;
    @(negedge HCLK); HRESETn = 1;
    @(negedge HCLK); idle();
    bus.host_req = 1; bus.host_we = 1; bus.host_addr = 12'd7;
    bus.host_wdata = 64'h1122334455667788; bus.host_be = 8'hFF;
    bus.IOPWREQ = 1; bus.IOPWADDR = 21'h0003A; bus.IOPWDATA = 8'h5C;
    bus.IOPRREQ = 1; bus.IOPRADDR = 21'h0003A;
    #1;
    total++;
    if ({bus.host_gnt, bus.IOPWWAIT, bus.IOPRWAIT, bus.ram_we} !== 4'b1111 || bus.ram_addr !== 12'd7) begin
      bad++; $display("FAIL rr_h got=%b addr=%h exp 1111 007",
        {bus.host_gnt, bus.IOPWWAIT, bus.IOPRWAIT, bus.ram_we}, bus.ram_addr);
    end
    @(negedge HCLK); bus.host_req = 0; #1;
    total++;
    if ({bus.host_gnt, bus.IOPWWAIT, bus.IOPRWAIT, bus.ram_we} !== 4'b0011 || bus.ram_be !== 8'h04) begin
      bad++; $display("FAIL rr_w got=%b be=%h exp 0011 04",
        {bus.host_gnt, bus.IOPWWAIT, bus.IOPRWAIT, bus.ram_we}, bus.ram_be);
    end
    @(negedge HCLK); bus.IOPWREQ = 0; #1;
    total++;
    if ({bus.host_gnt, bus.IOPWWAIT, bus.IOPRWAIT, bus.ram_en, bus.ram_we} !== 5'b00110 || bus.ram_addr !== 12'd7) begin
      bad++; $display("FAIL rr_r got=%b addr=%h exp 00110 007",
        {bus.host_gnt, bus.IOPWWAIT, bus.IOPRWAIT, bus.ram_en, bus.ram_we}, bus.ram_addr);
    end
    @(negedge HCLK); #1;
    total++;
    if ({bus.IOPRWAIT, bus.ram_en} !== 2'b00 || bus.IOPRDATA !== 8'h5C) begin
      bad++; $display("FAIL rr_rdata got wait/en=%b data=%h exp 00 5c", {bus.IOPRWAIT, bus.ram_en}, bus.IOPRDATA);
    end
    // Pointer now at R: host wins over W next.
    @(negedge HCLK); idle();
    bus.host_req = 1; bus.host_we = 1; bus.host_be = 8'h00;
    bus.IOPWREQ = 1; bus.IOPWADDR = 21'h00640;
    #1;
    total++;
    if ({bus.host_gnt, bus.IOPWWAIT} !== 2'b11) begin
      bad++; $display("FAIL rr_ptr_r got=%b exp 11", {bus.host_gnt, bus.IOPWWAIT});
    end
  endtask

  task automatic test_lock();
    @(negedge HCLK); idle();
    bus.host_lock = 1; bus.host_req = 1; bus.host_we = 1; bus.host_be = 8'h00;
    bus.host_addr = 12'd100;
    bus.IOPWREQ = 1; bus.IOPWADDR = 21'h00640; bus.IOPWDATA = 8'h00;
    for (int i = 0; i < LOCK_MAX; i++) begin
      if (i > 0) @(negedge HCLK);
      #1;
      total++;
      if ({bus.host_gnt, bus.IOPWWAIT} !== 2'b11) begin
        bad++; $display("FAIL lock_h%0d got=%b exp 11", i, {bus.host_gnt, bus.IOPWWAIT});
      end
    end
    @(negedge HCLK); #1;
    total++;
    if ({bus.host_gnt, bus.IOPWWAIT, bus.ram_we} !== 3'b001 || bus.ram_addr !== 12'd200) begin
      bad++; $display("FAIL lock_w got=%b addr=%h exp 001 0c8",
        {bus.host_gnt, bus.IOPWWAIT, bus.ram_we}, bus.ram_addr);
    end
    @(negedge HCLK); #1;
    total++;
    if ({bus.host_gnt, bus.IOPWWAIT} !== 2'b11) begin
      bad++; $display("FAIL lock_resume got=%b exp 11", {bus.host_gnt, bus.IOPWWAIT});
    end
  endtask

  task automatic test_host_rw();
    @(negedge HCLK); idle();
    bus.host_req = 1; bus.host_we = 1; bus.host_addr = 12'd3;
    bus.host_wdata = 64'h0123456789ABCDEF; bus.host_be = 8'hFF;
    #1;
    total++;
    if ({bus.host_gnt, bus.ram_we, bus.host_rvalid} !== 3'b110 || bus.ram_addr !== 12'd3 ||
        bus.ram_wdata !== 64'h0123456789ABCDEF) begin
      bad++; $display("FAIL hw got=%b addr=%h wd=%h exp 110 003 0123456789abcdef",
        {bus.host_gnt, bus.ram_we, bus.host_rvalid}, bus.ram_addr, bus.ram_wdata);
    end
    @(negedge HCLK); bus.host_we = 0; bus.host_wdata = '0; #1;
    total++;
    if ({bus.host_gnt, bus.ram_we, bus.host_rvalid} !== 3'b100) begin
      bad++; $display("FAIL hr_grant got=%b exp 100", {bus.host_gnt, bus.ram_we, bus.host_rvalid});
    end
    @(negedge HCLK); bus.host_req = 0; #1;
    total++;
    if ({bus.host_gnt, bus.host_rvalid, bus.ram_en} !== 3'b010 || bus.host_rdata !== 64'h0123456789ABCDEF) begin
      bad++; $display("FAIL hr_data got=%b rd=%h exp 010 0123456789abcdef",
        {bus.host_gnt, bus.host_rvalid, bus.ram_en}, bus.host_rdata);
    end
    @(negedge HCLK); #1;
    total++;
    if (bus.host_rvalid !== 1'b0 || bus.host_rdata !== 64'h0) begin
      bad++; $display("FAIL hr_after got v=%b rd=%h exp 0 0", bus.host_rvalid, bus.host_rdata);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge HCLK); idle();
    bus.host_req = 1; bus.host_addr = 12'd3;
    #1;
    total++;
    if (bus.host_gnt !== 1'b1) begin
      bad++; $display("FAIL b2b_g0 got=%b exp 1", bus.host_gnt);
    end
    @(negedge HCLK); bus.host_addr = 12'd7; #1;
    total++;
    if ({bus.host_gnt, bus.host_rvalid} !== 2'b11 || bus.host_rdata !== 64'h0123456789ABCDEF) begin
      bad++; $display("FAIL b2b_d0 got=%b rd=%h exp 11 0123456789abcdef",
        {bus.host_gnt, bus.host_rvalid}, bus.host_rdata);
    end
    @(negedge HCLK); idle(); #1;
    total++;
    if (bus.host_rvalid !== 1'b1 || bus.host_rdata !== 64'h11223344555C7788) begin
      bad++; $display("FAIL b2b_d1 got v=%b rd=%h exp 1 11223344555c7788", bus.host_rvalid, bus.host_rdata);
    end
  endtask

  task automatic test_reset_mid_read();
    @(negedge HCLK); idle();
    bus.host_req = 1; bus.host_we = 1; bus.host_be = 8'h00;
    @(negedge HCLK); idle();
    bus.IOPRREQ = 1; bus.IOPRADDR = 21'h00005;
    #1;
    total++;
    if ({bus.IOPRWAIT, bus.ram_en, bus.ram_we} !== 3'b110) begin
      bad++; $display("FAIL rst_pre got=%b exp 110", {bus.IOPRWAIT, bus.ram_en, bus.ram_we});
    end
    #1 HRESETn = 0;
    @(negedge HCLK); #1;
    total++;
    if ({bus.IOPRWAIT, bus.host_rvalid} !== 2'b10 || bus.IOPRDATA !== 8'h00) begin
      bad++; $display("FAIL rst_drop got wait/rv=%b data=%h exp 10 00", {bus.IOPRWAIT, bus.host_rvalid}, bus.IOPRDATA);
    end
    HRESETn = 1;
    bus.host_req = 1; bus.host_we = 1; bus.IOPWREQ = 1; bus.IOPWADDR = 21'h00640;
    #1;
    total++;
    if ({bus.host_gnt, bus.IOPWWAIT, bus.IOPRWAIT} !== 3'b111) begin
      bad++; $display("FAIL rst_ptr got=%b exp 111", {bus.host_gnt, bus.IOPWWAIT, bus.IOPRWAIT});
    end
    @(negedge HCLK); bus.host_req = 0; #1;
    total++;
    if ({bus.host_gnt, bus.IOPWWAIT, bus.IOPRWAIT} !== 3'b001) begin
      bad++; $display("FAIL rst_w got=%b exp 001", {bus.host_gnt, bus.IOPWWAIT, bus.IOPRWAIT});
    end
    @(negedge HCLK); bus.IOPWREQ = 0; #1;
    total++;
    if ({bus.IOPRWAIT, bus.ram_en, bus.ram_we} !== 3'b110 || bus.ram_addr !== 12'd0) begin
      bad++; $display("FAIL rst_r got=%b addr=%h exp 110 000", {bus.IOPRWAIT, bus.ram_en, bus.ram_we}, bus.ram_addr);
    end
    @(negedge HCLK); #1;
    total++;
    if (bus.IOPRWAIT !== 1'b0 || bus.IOPRDATA !== 8'hA5) begin
      bad++; $display("FAIL rst_rdata got wait=%b data=%h exp 0 a5", bus.IOPRWAIT, bus.IOPRDATA);
    end
    @(negedge HCLK); idle();
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = '0;
    idle();
    test_reset();
    test_iop_write();
    test_iop_read();
    test_round_robin();
    test_lock();
    test_host_rw();
    test_back_to_back();
    test_reset_mid_read();
    repeat (2) @(negedge HCLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mfspm_port_arbiter.md
Name: mfspm_port_arbiter

Overview:
- Time-multiplexes one single-port, 64-bit, byte-enabled SPM SRAM bank between three requesters:
  - the host front end (64-bit word accesses, already decoded from AHB);
  - the IOP408 byte read port;
  - the IOP408 byte write port.
- Round-robin arbitration, with a bounded host lock for bursts.
- Generates the IOP408 wait handshakes and returns read data with fixed latency.
- Sits between the AHB SPM slave front end / IOP408 data bus and the SRAM macro.

Parameters:
- AW, 12, SRAM word-address width (64-bit words; 4096 words = 32 KiB).
- LOCK_MAX, 16, maximum consecutive locked host grants while another requester waits.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  asynchronous active-low reset.
- host_req  in  1  host access request; payload held stable until host_gnt.
- host_lock  in  1  host burst lock (absolute priority, bounded by LOCK_MAX).
- host_we  in  1  1 = write.
- host_addr  in  AW  word address.
- host_wdata  in  64  write data.
- host_be  in  8  byte enables.
- host_gnt  out  1  access issued to SRAM this cycle.
- host_rvalid  out  1  host read data valid.
- host_rdata  out  64  host read data.
- IOPRREQ  in  1  IOP read request.
- IOPRADDR  in  21  IOP read byte address; bits [AW+2:0] used.
- IOPRDATA  out  8  IOP read byte.
- IOPRWAIT  out  1  IOP read stall.
- IOPWREQ  in  1  IOP write request.
- IOPWADDR  in  21  IOP write byte address; bits [AW+2:0] used.
- IOPWDATA  in  8  IOP write byte.
- IOPWWAIT  out  1  IOP write stall.
- ram_en  out  1  SRAM access enable.
- ram_we  out  1  SRAM write.
- ram_addr  out  AW  SRAM word address.
- ram_wdata  out  64  SRAM write data.
- ram_be  out  8  SRAM byte enables.
- ram_rdata  in  64  SRAM read data, one cycle after ram_en & ~ram_we.

Behaviour:
- State registers:
  - ptr: last granted requester, one of {H, W, R}; reset = R.
  - rd_pend: IOP read data cycle; reset 0.
  - lane_q[2:0]: reset 0.
  - hrd_pend: reset 0.
  - lock_cnt: width clog2(LOCK_MAX+1); reset 0.
- Eligibility:
  - H eligible = host_req.
  - W eligible = IOPWREQ.
  - R eligible = IOPRREQ & ~rd_pend.
- Grant (combinational, at most one per cycle):
  - If host_lock & host_req & lock_cnt < LOCK_MAX: grant H.
  - Otherwise round-robin starting after ptr, order H -> W -> R -> H. When lock_cnt = LOCK_MAX, H is excluded if W or R is eligible.
- ptr update: loads the granted requester on any grant; unchanged when there is no grant.
- lock_cnt:
  - +1 on a locked H grant while W or R is eligible;
  - cleared on any W/R grant or when host_lock = 0;
  - saturates at LOCK_MAX.
- SRAM drive on grant, ram_en = 1:
  - H: ram_we = host_we, ram_addr = host_addr, ram_wdata = host_wdata, ram_be = host_be.
  - W: ram_we = 1, ram_addr = IOPWADDR[AW+2:3], ram_wdata = IOPWDATA replicated ×8, ram_be = one-hot(IOPWADDR[2:0]).
  - R: ram_we = 0, ram_addr = IOPRADDR[AW+2:3], ram_be = 8'hFF.
  - No grant: ram_en = 0 and all other SRAM outputs 0.
- Host:
  - host_gnt = H granted.
  - Granted read sets hrd_pend for the next cycle.
  - host_rvalid = hrd_pend; host_rdata = hrd_pend ? ram_rdata : 0.
  - Read latency: 1 cycle after grant.
- IOP write:
  - IOPWWAIT = IOPWREQ & ~(W granted).
  - The write completes in its grant cycle (0 wait cycles when uncontended).
- IOP read:
  - R grant sets rd_pend = 1 and lane_q = IOPRADDR[2:0] for the next cycle.
  - IOPRWAIT = IOPRREQ & ~rd_pend.
  - IOPRDATA = rd_pend ? ram_rdata[8*lane_q +: 8] : 0.
  - Minimum read = 1 wait cycle plus 1 data cycle.
  - IOPRREQ still high in the cycle after the data cycle is a new access.
- Boundaries:
  - No requests: SRAM idle, all outputs 0 except the combinational waits.
  - Back-to-back host grants are allowed every cycle while W and R are idle.
  - Payload changes while not granted are tolerated; the value sampled at grant is used.
  - Reset mid-access: all registers clear asynchronously; an in-flight read's data is dropped (rvalid/rd_pend = 0).

Test Plan:
1. Reset, then IOPWREQ with IOPWADDR = 0x00005, data 0xA5 -> same cycle: IOPWWAIT = 0, ram_addr = 0, ram_be = 8'h20, ram_wdata = 0xA5A5…A5.
2. Then IOPRREQ with IOPRADDR = 0x00005 -> cycle 0: IOPRWAIT = 1, ram_en = 1, ram_we = 0. Cycle 1: IOPRWAIT = 0, IOPRDATA = 0xA5.
3. host_req, IOPWREQ and IOPRREQ all asserted from reset (ptr = R) -> grants H, W, R on consecutive cycles. The IOP read data cycle follows the R grant; ptr ends at R.
4. host_lock = 1 with host_req held continuously and IOPWREQ held -> 16 consecutive H grants, then W granted on cycle 17 (IOPWWAIT low for that cycle only), then H resumes.
5. Host write 0x0123456789ABCDEF at word 3 with be = 8'hFF, then host read of word 3 -> host_rvalid one cycle after the read grant, host_rdata = 0x0123456789ABCDEF.
6. HRESETn pulsed low during the IOP read wait cycle -> rd_pend = 0, IOPRDATA = 0, ptr = R. After release, IOPRREQ is re-arbitrated from scratch.
